multpe_seq: RTL
===============

// Module: multpe_seq
// PURPOSE
//  Initiator for the multpe operand-load/start/done protocol. Accepts one 3-operand command
//  (three IEEE-754 doubles) on a valid/ready port and writes it into multpe at addresses 0..2.
//  It then pulses start, waits for done and returns the 128-bit result on a valid/ready port.
//  Sits between the job dispatcher and one multpe instance; it replaces hand-sequenced pokes.
// PARAMETERS
//  DW        64     operand width (multpe inp width)
//  RW        128    result width (multpe out width)
//  TIMEOUT   1024   max cycles in WAIT before the job is aborted with res_err=1
//  CNT_W     11     width of wait counter; must hold TIMEOUT
// PORTS
//  clk        in   1     single clock, all logic on posedge
//  rst        in   1     synchronous, active-high reset
//  cmd_valid  in   1     command present
//  cmd_ready  out  1     block can accept a command (high only in IDLE)
//  cmd_op0    in   DW    operand for multpe addr 0
//  cmd_op1    in   DW    operand for multpe addr 1
//  cmd_op2    in   DW    operand for multpe addr 2
//  pe_addr    out  2     multpe operand address
//  pe_inp     out  DW    multpe operand data
//  pe_valid   out  1     multpe operand write strobe
//  pe_start   out  1     multpe start, one-cycle pulse
//  pe_done    in   1     multpe completion (pulse or level; first high cycle in WAIT counts)
//  pe_out     in   RW    multpe result, sampled on the done cycle
//  res_valid  out  1     result held for consumer
//  res_ready  in   1     consumer accepts result
//  res_data   out  RW    captured result (0 on timeout)
//  res_err    out  1     1 = job aborted by timeout
//  busy       out  1     high in every state except IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; cmd_ready=1; pe_valid=0; pe_start=0; pe_addr=0; pe_inp=0.
//    Also res_valid=0, res_data=0, res_err=0, busy=0, wait counter=0.
//  - All outputs are registered.
//  - FSM: IDLE -> L0 -> L1 -> L2 -> GO -> WAIT -> RESP -> IDLE.
//  - IDLE: on cmd_valid&&cmd_ready, latch op0..op2 into internal regs. Next state is L0.
//  - L0/L1/L2: one cycle each with pe_valid=1, pe_addr=0/1/2, pe_inp=latched op0/op1/op2.
//  - GO: pe_valid=0, pe_start=1 for exactly one cycle. Clear wait counter.
//  - WAIT: pe_start=0. Counter increments each cycle.
//    - pe_done=1: capture pe_out into res_data, set res_err=0 and res_valid=1, go to RESP.
//    - counter reaches TIMEOUT-1 without done: res_data=0, res_err=1, res_valid=1, go to RESP.
//    - If done and timeout land on the same cycle, done wins (res_err=0).
//  - RESP: hold res_valid/res_data/res_err stable until res_ready.
//    - On res_valid&&res_ready: res_valid=0 next cycle, then IDLE.
//  - Latency: cmd accept to first pe_valid = 1 cycle; accept to pe_start = 4 cycles.
//    pe_done to res_valid = 1 cycle.
//  - pe_done outside WAIT is ignored; a stale level-high done from a previous job must not
//    complete a new job early. Only a done seen after GO counts.
//  - pe_out is ignored on every cycle except the accepted done cycle.
//  - cmd_valid while busy: cmd_ready=0, command not consumed, no state change.
//  - Back-to-back: a new command is accepted no earlier than the cycle after the RESP handshake.
//  - rst mid-job (any state): return to reset values next cycle. Any held result is dropped.
//    pe_valid/pe_start go low with no partial write replay.
//  - No arithmetic beyond the counter. The counter saturates and never wraps.
// STRUCTURE
//  - Shared package multpe_pkg holds:
//    - state typedef (IDLE,L0,L1,L2,GO,WAIT,RESP, 3-bit encoding);
//    - address constants ADDR_OP0=2'd0, ADDR_OP1=2'd1, ADDR_OP2=2'd2;
//    - DW/RW defaults.
//  - Single flat module. No sub-module is needed; the FSM, operand regs and counter fit in one.
// TESTING
//  - Bench uses a behavioural multpe model: done arrives N cycles after start.
//    out = {op0,op1} captured at addrs 0/1.
//  - Basic: cmd op0=64'h40092AF77DB8CC83, op1=64'h4018F0329122D34E, op2=op0; model N=20.
//    -> pe_valid on 3 consecutive cycles with addr 0,1,2, then pe_start pulse.
//    -> res_valid 1 cycle after done, res_data={op0,op1}, res_err=0.
//  - Backpressure: res_ready=0 for 15 cycles after res_valid.
//    -> res_data/res_err stable, cmd_ready=0 throughout; a cmd offered meanwhile is not taken.
//  - Second job: op0=64'hC035A77C30B4E545, op1=64'h40846EF84C02BC6E, issued right after RESP.
//    -> accepted the cycle after the handshake, result {op0,op1}.
//  - Timeout: model never asserts done, TIMEOUT=32 -> res_valid exactly 32 cycles after GO.
//    -> res_err=1, res_data=0; a subsequent job completes normally.
//  - Stale done: pe_done held high before and during the load phase.
//    -> no capture before GO; capture on the first WAIT cycle.
//  - Reset mid-WAIT: rst asserted for 1 cycle at WAIT+5.
//    -> all outputs at reset values next cycle, cmd_ready=1; a late done is ignored.

Source files
------------

// File: rtl/multpe_pkg.sv
// Shared definitions for the multpe command sequencer: FSM encoding,
// operand address map and default data widths.
package multpe_pkg;

  localparam int DW_DEF = 64;
  localparam int RW_DEF = 128;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L0   = 3'd1,
    L1   = 3'd2,
    L2   = 3'd3,
    GO   = 3'd4,
    WAIT = 3'd5,
    RESP = 3'd6
  } state_t;

  localparam logic [1:0] ADDR_OP0 = 2'd0;
  localparam logic [1:0] ADDR_OP1 = 2'd1;
  localparam logic [1:0] ADDR_OP2 = 2'd2;

endpackage

// File: rtl/multpe_seq.sv
// Initiator for multpe: takes one 3-operand command, writes it to addresses 0..2,
// pulses start, waits for done (or times out) and presents the 128-bit result.
module multpe_seq
  import multpe_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int RW      = RW_DEF,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_op0,
  input  logic [DW-1:0] cmd_op1,
  input  logic [DW-1:0] cmd_op2,
  output logic [1:0]    pe_addr,
  output logic [DW-1:0] pe_inp,
  output logic          pe_valid,
  output logic          pe_start,
  input  logic          pe_done,
  input  logic [RW-1:0] pe_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [RW-1:0] res_data,
  output logic          res_err,
  output logic          busy
);

  state_t          state_r;
  state_t          state_nx_s;
  logic [DW-1:0]   op1_r;
  logic [DW-1:0]   op2_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic            accept_s;
  logic            hs_s;
  logic            timeout_s;

  logic            cmd_ready_nx_s;
  logic            busy_nx_s;
  logic            pe_valid_nx_s;
  logic [1:0]      pe_addr_nx_s;
  logic [DW-1:0]   pe_inp_nx_s;
  logic            pe_start_nx_s;
  logic            res_valid_nx_s;
  logic [RW-1:0]   res_data_nx_s;
  logic            res_err_nx_s;

  assign accept_s  = (state_r == IDLE) && cmd_valid && cmd_ready;
  assign hs_s      = res_valid && res_ready;
  assign cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : (cnt_r + CNT_W'(1));
  // Timeout fires on the WAIT cycle whose increment lands the counter on TIMEOUT-1.
  assign timeout_s = (cnt_inc_s == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = L0;
        end else begin
          state_nx_s = IDLE;
        end
      end
      L0:   state_nx_s = L1;
      L1:   state_nx_s = L2;
      L2:   state_nx_s = GO;
      GO:   state_nx_s = WAIT;
      WAIT: begin
        if (pe_done || timeout_s) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = WAIT;
        end
      end
      RESP: begin
        if (hs_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Output next-values, derived from the state being entered so outputs can be registered
  always_comb begin
    cmd_ready_nx_s = (state_nx_s == IDLE);
    busy_nx_s      = (state_nx_s != IDLE);
    pe_valid_nx_s  = 1'b0;
    pe_addr_nx_s   = ADDR_OP0;
    pe_inp_nx_s    = {DW{1'b0}};
    pe_start_nx_s  = 1'b0;
    res_valid_nx_s = res_valid;
    res_data_nx_s  = res_data;
    res_err_nx_s   = res_err;
    case (state_nx_s)
      // op0 is driven straight from the command port on the accept cycle
      L0: begin
        pe_valid_nx_s = 1'b1;
        pe_addr_nx_s  = ADDR_OP0;
        pe_inp_nx_s   = cmd_op0;
      end
      L1: begin
        pe_valid_nx_s = 1'b1;
        pe_addr_nx_s  = ADDR_OP1;
        pe_inp_nx_s   = op1_r;
      end
      L2: begin
        pe_valid_nx_s = 1'b1;
        pe_addr_nx_s  = ADDR_OP2;
        pe_inp_nx_s   = op2_r;
      end
      GO: begin
        pe_start_nx_s = 1'b1;
      end
      RESP: begin
        if (state_r == WAIT) begin
          res_valid_nx_s = 1'b1;
          if (pe_done) begin
            res_data_nx_s = pe_out;
            res_err_nx_s  = 1'b0;
          end else begin
            res_data_nx_s = {RW{1'b0}};
            res_err_nx_s  = 1'b1;
          end
        end else begin
          res_valid_nx_s = res_valid;
        end
      end
      IDLE: begin
        res_valid_nx_s = 1'b0;
      end
      default: begin
        pe_valid_nx_s = 1'b0;
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      pe_valid  <= 1'b0;
      pe_addr   <= ADDR_OP0;
      pe_inp    <= {DW{1'b0}};
      pe_start  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= {RW{1'b0}};
      res_err   <= 1'b0;
    end else begin
      cmd_ready <= cmd_ready_nx_s;
      busy      <= busy_nx_s;
      pe_valid  <= pe_valid_nx_s;
      pe_addr   <= pe_addr_nx_s;
      pe_inp    <= pe_inp_nx_s;
      pe_start  <= pe_start_nx_s;
      res_valid <= res_valid_nx_s;
      res_data  <= res_data_nx_s;
      res_err   <= res_err_nx_s;
    end
  end

  // Operand latch for the later load cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      op1_r <= {DW{1'b0}};
      op2_r <= {DW{1'b0}};
    end else if (accept_s) begin
      op1_r <= cmd_op1;
      op2_r <= cmd_op2;
    end else begin
      op1_r <= op1_r;
      op2_r <= op2_r;
    end
  end

  // Wait counter: cleared in GO, saturating increment in WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        GO:      cnt_r <= {CNT_W{1'b0}};
        WAIT:    cnt_r <= cnt_inc_s;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule
